// File: rtl/irq_priority_arbiter_if.sv
// Valid/ready grant channel between the interrupt arbiter and its consumer.
// The arbiter drives the index and valid flag; the consumer drives ready.
interface irq_priority_arbiter_if #(
    parameter int IDXW = 3
);
    logic            irq_valid;
    logic            irq_ready;
    logic [IDXW-1:0] irq_idx;

    modport master (
        output irq_valid,
        output irq_idx,
        input  irq_ready
    );

    modport slave (
        input  irq_valid,
        input  irq_idx,
        output irq_ready
    );
endinterface

// File: rtl/irq_priority_arbiter.sv
// Interrupt front end: synchronises request lines, latches them as pending events and
// grants the highest-index unmasked pending line over a valid/ready channel.
module irq_priority_arbiter #(
    parameter int N_REQ     = 8,
    parameter int IDXW      = 3,
    parameter int EDGE_MODE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_in_i,
    input  logic [N_REQ-1:0]     mask_i,
    input  logic                 clr_all_i,
    irq_priority_arbiter_if.master irq_if,
    output logic [N_REQ-1:0]     pending_o,
    output logic [N_REQ-1:0]     overflow_o,
    output logic [7:0]           grant_cnt_o
);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t           state_q;
    logic [N_REQ-1:0] s1_q, s2_q, s3_q;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [N_REQ-1:0] overflow_q, overflow_d;
    logic [N_REQ-1:0] event_w, accept_w, eligible_w;
    logic [IDXW-1:0]  idx_q, sel_w;
    logic             valid_q;
    logic [7:0]       cnt_q;
    logic             handshake_w;

    // s3 holds the previous synchronised value so a rising edge can be detected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= req_in_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    generate
        if (EDGE_MODE != 0) begin : g_edge
            assign event_w = s2_q & ~s3_q;
        end else begin : g_level
            assign event_w = s2_q;
        end
    endgenerate

    // A handshake racing a clear is dropped entirely.
    assign handshake_w = valid_q & irq_if.irq_ready & ~clr_all_i;
    assign eligible_w  = pending_q & ~mask_i;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bit
            assign accept_w[gi]   = handshake_w && (idx_q == IDXW'(gi));
            // A new event on the line being served re-arms it rather than being lost.
            assign pending_d[gi]  = clr_all_i ? 1'b0
                                  : (event_w[gi] | (pending_q[gi] & ~accept_w[gi]));
            assign overflow_d[gi] = clr_all_i ? 1'b0
                                  : (overflow_q[gi] |
                                     ((EDGE_MODE != 0) && event_w[gi] &&
                                      pending_q[gi] && !accept_w[gi]));
        end
    endgenerate

    always_comb begin
        sel_w = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (eligible_w[i]) begin
                sel_w = IDXW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            overflow_q <= '0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    // The presented index is frozen until accepted or cleared; no re-prioritisation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (!clr_all_i && (eligible_w != '0)) begin
                        idx_q   <= sel_w;
                        valid_q <= 1'b1;
                        state_q <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (clr_all_i) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end else if (irq_if.irq_ready) begin
                        cnt_q   <= cnt_q + 8'd1;
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign irq_if.irq_valid = valid_q;
    assign irq_if.irq_idx   = idx_q;
    assign pending_o        = pending_q;
    assign overflow_o       = overflow_q;
    assign grant_cnt_o      = cnt_q;

endmodule

// File: doc/irq_priority_arbiter.md
Name: irq_priority_arbiter

Overview:
- Sequential front end for the 8-line priority path.
- Synchronises raw request lines and captures them into a pending register, with edge or level capture.
- Masks the pending bits, selects the highest-index eligible request (bit 7 highest) and presents its 3-bit index on a valid/ready handshake.
- Clears the served pending bit on acceptance. The valid flag removes the "no request" vs "request 0" ambiguity of a bare index.

Parameters:
- N_REQ, 8, number of request lines (design and verification at 8 only).
- IDXW, 3, index width, equal to log2(N_REQ).
- EDGE_MODE, 1, 1 = rising-edge capture, 0 = level capture.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_in  input  8  raw asynchronous request lines.
- mask  input  8  1 = line ineligible for selection (pending still captured).
- clr_all  input  1  synchronous clear of pending, overflow and FSM.
- irq_valid  output  1  irq_idx holds a granted request.
- irq_ready  input  1  consumer accepts irq_idx.
- irq_idx  output  3  index of presented request.
- pending  output  8  current pending register.
- overflow  output  8  sticky per line: event lost because the bit was already pending.
- grant_cnt  output  8  count of completed handshakes, wraps 255->0.

Behaviour:
- Reset (rst_n low, asynchronous): pending=0, overflow=0, grant_cnt=0, irq_valid=0, irq_idx=0, sync/history flops=0, FSM=IDLE. Release is synchronous to clk.
- Sync: req_in passes through 2 flops (s1, s2), then history flop s3.
  - event = s2 & ~s3 when EDGE_MODE=1; event = s2 when EDGE_MODE=0.
- Pending update per bit i, each clock:
  - clr_all: 0.
  - else if event[i]: 1. Set wins over same-cycle acceptance of i.
  - else if handshake and irq_idx==i: 0.
  - else hold.
- Overflow[i]: set when event[i] and pending[i]==1 and bit i is not being accepted this cycle. In EDGE_MODE only (level mode never sets it). Cleared only by clr_all or reset.
- eligible = pending & ~mask. sel = highest set bit of eligible.
- FSM:
  - IDLE: irq_valid=0. If eligible!=0 and !clr_all: register irq_idx=sel, go to PRESENT.
  - PRESENT: irq_valid=1, irq_idx frozen. No re-prioritisation on higher arrivals or mask changes; the grant is never withdrawn except by clr_all.
    - On irq_valid & irq_ready (handshake): clear pending bit, grant_cnt+1, go to IDLE.
- Throughput: one grant per 2 cycles max; the IDLE cycle re-evaluates.
- clr_all in any state: next state IDLE, irq_valid=0 next cycle. Handshake in the same cycle is ignored (no count, no clear beyond clr_all). irq_idx holds its last value.
- Latency, EDGE_MODE=1: req_in low at edge k-1, high at edge k.
  - s2=1 at k+1, pending set at k+2, irq_valid=1 at k+3 (FSM idle, not masked).
- irq_idx is only meaningful while irq_valid=1. The consumer must not rely on it otherwise.
- grant_cnt wraps silently; no saturation.
- Reset asserted mid-handshake: all state cleared immediately. A request still held high after reset is re-captured as an edge once synced, because s3 resets to 0.

Test Plan:
- Single request: after reset, pulse req_in=8'h04 high for 3 cycles; irq_ready=1 -> irq_valid rises at edge k+3 with irq_idx=2; pending returns to 0 one cycle after handshake; grant_cnt=1.
- Priority and ordering: req_in=8'h91 simultaneously, irq_ready=1 -> grants in order idx 7, 4, 0 on alternate cycles, grant_cnt=3, pending=0.
- Hold stability: grant idx 3 with irq_ready=0, then raise req bit 6 -> irq_idx stays 3 until ready. After the handshake plus the IDLE cycle, idx 6 is presented.
- Mask: pending 8'h81, mask=8'h80 -> idx 0 granted, bit 7 stays pending. Clearing mask -> idx 7 granted.
- Overflow and set-wins: second edge on bit 5 while pending and not granted (irq_ready=0) -> overflow=8'h20. Edge on bit 5 in the exact cycle idx 5 is accepted -> pending[5] remains 1 and no overflow.
- clr_all during PRESENT with irq_ready=1 in the same cycle -> irq_valid=0 next cycle, pending=0, overflow=0, grant_cnt unchanged. Separately, drive 256 handshakes and check grant_cnt wraps to 0.
